// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared types and address helper for the BRAM write arbiter.
// hold_t is sized for the default DATA_W/WE_W of bram_wr_arbiter.
package bram_arb_pkg;
  localparam int HOLD_DATA_W = 32;
  localparam int HOLD_WE_W = 5;
  typedef enum logic [1:0] {IDLE, FILL, FULL} region_state_t;
  typedef struct packed {
    logic                   valid;
    logic [HOLD_WE_W-1:0]   we;
    logic [HOLD_DATA_W-1:0] data;
  } hold_t;
  function automatic int region_base(input int ch, input int depth);
    return ch * depth;
  endfunction
endpackage

// File: rtl/bram_wr_arbiter_if.sv
// bram_wr_arbiter_if: packer-side request/lock signals plus the BRAM port A write bus.
interface bram_wr_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32,
  parameter int WE_W   = 5,
  parameter int ADDR_W = 11,
  parameter int OVF_W  = 16
);
  logic [N_REQ*WE_W-1:0]   req_we;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_start;
  logic [N_REQ-1:0]        rd_done;
  logic [N_REQ-1:0]        req_locked;
  logic [N_REQ-1:0]        region_full;
  logic [ADDR_W-1:0]       bram_addr;
  logic [DATA_W-1:0]       bram_din;
  logic [WE_W-1:0]         bram_we;
  logic [OVF_W-1:0]        ovf_cnt;
  modport slave (
    input  req_we, req_data, req_start, rd_done,
    output req_locked, region_full, bram_addr, bram_din, bram_we, ovf_cnt
  );
  modport master (
    output req_we, req_data, req_start, rd_done,
    input  req_locked, region_full, bram_addr, bram_din, bram_we, ovf_cnt
  );
endinterface

// File: rtl/bram_wr_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot grant over N requests; round-robin by default,
// fixed lowest-index priority when ARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk_120,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
`ifdef ARB_FIXED_PRIO_EN
  always_comb gnt = req & (~req + 1'b1);
`else
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] p_q, p_d;
  // Walk offsets from farthest to nearest so the nearest requester after p wins.
  always_comb begin
    gnt = '0;
    p_d = p_q;
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = int'(p_q) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        gnt = '0;
        gnt[idx] = 1'b1;
        p_d = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end
  always_ff @(posedge clk_120 or posedge rst)
    if (rst) p_q <= '0;
    else p_q <= p_d;
`endif
endmodule

// File: rtl/bram_wr_arbiter.sv
// bram_wr_arbiter: shares one BRAM write port between N_REQ packer regions with
// per-region IDLE/FILL/FULL lock handshake. ARB_FIXED_PRIO_EN selects fixed priority.
module bram_wr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int DATA_W       = HOLD_DATA_W,
  parameter int WE_W         = HOLD_WE_W,
  parameter int REGION_DEPTH = 1024,
  parameter int PTR_W        = 10,
  parameter int ADDR_W       = 11,
  parameter int OVF_W        = 16
) (
  input logic clk_120,
  input logic rst,
  bram_wr_arbiter_if.slave bus
);
  region_state_t     st_q [N_REQ];
  region_state_t     st_d [N_REQ];
  logic [PTR_W-1:0]  ptr_q [N_REQ];
  logic [PTR_W-1:0]  ptr_d [N_REQ];
  hold_t             hold_q [N_REQ];
  hold_t             hold_d [N_REQ];
  logic [N_REQ-1:0]  req, gnt, locked_q, locked_d, full_q, full_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [WE_W-1:0]   we_q, we_d;
  logic [OVF_W-1:0]  ovf_q, ovf_d;
  logic [OVF_W:0]    ovf_sum;
  logic [3:0]        drops;
  // A start in FILL discards the pending word, so it must not win the port.
  always_comb
    for (int i = 0; i < N_REQ; i++)
      req[i] = hold_q[i].valid && st_q[i] == FILL && !bus.req_start[i];
  rr_arbiter #(.N(N_REQ)) u_arb (.clk_120(clk_120), .rst(rst), .req(req), .gnt(gnt));
  always_comb begin
    addr_d = addr_q;
    din_d = din_q;
    we_d = '0;
    drops = '0;
    for (int i = 0; i < N_REQ; i++) begin
      logic start, wnz, cap;
      start = bus.req_start[i];
      wnz = |bus.req_we[i*WE_W +: WE_W];
      st_d[i] = st_q[i];
      ptr_d[i] = ptr_q[i];
      hold_d[i] = hold_q[i];
      if (gnt[i]) begin
        addr_d = ADDR_W'(region_base(i, REGION_DEPTH)) + ADDR_W'(ptr_q[i]);
        din_d = hold_q[i].data;
        we_d = hold_q[i].we;
        ptr_d[i] = ptr_q[i] + 1'b1;
        hold_d[i].valid = 1'b0;
        if (ptr_q[i] == PTR_W'(REGION_DEPTH - 1)) st_d[i] = FULL;
      end
      if (st_q[i] == IDLE && start) begin
        st_d[i] = FILL;
        ptr_d[i] = '0;
      end else if (st_q[i] == FILL && start) begin
        ptr_d[i] = '0;
        hold_d[i].valid = 1'b0;
      end else if (st_q[i] == FULL && bus.rd_done[i]) begin
        st_d[i] = start ? FILL : IDLE;
        ptr_d[i] = '0;
      end
      // Capture only into a region that stays/becomes FILL with a free holding slot.
      cap = wnz && st_d[i] == FILL && !hold_d[i].valid;
      if (cap) hold_d[i] = '{1'b1, bus.req_we[i*WE_W +: WE_W], bus.req_data[i*DATA_W +: DATA_W]};
      if (wnz && !cap && st_q[i] != IDLE) drops = drops + 1'b1;
      locked_d[i] = st_d[i] != FILL;
      full_d[i] = st_d[i] == FULL;
    end
    ovf_sum = {1'b0, ovf_q} + (OVF_W+1)'(drops);
    ovf_d = ovf_sum[OVF_W] ? '1 : ovf_sum[OVF_W-1:0];
  end
  always_ff @(posedge clk_120 or posedge rst)
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        st_q[i] <= IDLE;
        ptr_q[i] <= '0;
        hold_q[i] <= '0;
      end
      locked_q <= '0;
      full_q <= '0;
      addr_q <= '0;
      din_q <= '0;
      we_q <= '0;
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        st_q[i] <= st_d[i];
        ptr_q[i] <= ptr_d[i];
        hold_q[i] <= hold_d[i];
      end
      locked_q <= locked_d;
      full_q <= full_d;
      addr_q <= addr_d;
      din_q <= din_d;
      we_q <= we_d;
      ovf_q <= ovf_d;
    end
  assign bus.req_locked = locked_q;
  assign bus.region_full = full_q;
  assign bus.bram_addr = addr_q;
  assign bus.bram_din = din_q;
  assign bus.bram_we = we_q;
  assign bus.ovf_cnt = ovf_q;
endmodule

// File: tb/tb_bram_wr_arbiter.sv
// tb_bram_wr_arbiter: directed vectors for bram_wr_arbiter with N_REQ=2, REGION_DEPTH=8.
module tb_bram_wr_arbiter;
  logic clk, rst;
  int n_vec = 0;
  int n_err = 0;
  bram_wr_arbiter_if #(.N_REQ(2), .DATA_W(32), .WE_W(5), .ADDR_W(4), .OVF_W(16)) bus ();
  bram_wr_arbiter #(
    .N_REQ(2), .DATA_W(32), .WE_W(5), .REGION_DEPTH(8), .PTR_W(3), .ADDR_W(4), .OVF_W(16)
  ) dut (.clk_120(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1;
    bus.req_we = '0;
    bus.req_data = '0;
    bus.req_start = '0;
    bus.rd_done = '0;
    repeat (2) step();
    chk("rst_locked", bus.req_locked, 0);
    chk("rst_we", bus.bram_we, 0);
    chk("rst_ovf", bus.ovf_cnt, 0);
    rst = 1'b0;
    step();
    chk("idle_locked", bus.req_locked, 2'b11);
    chk("idle_full", bus.region_full, 0);
    bus.req_we[4:0] = 5'h0F; bus.req_data[31:0] = 32'h99;
    step();
    bus.req_we = '0;
    step();
    chk("idle_drop_ovf", bus.ovf_cnt, 0);
    chk("idle_drop_we", bus.bram_we, 0);
    // single channel
    bus.req_start = 2'b01; step(); bus.req_start = '0;
    chk("fill_locked", bus.req_locked, 2'b10);
    bus.req_we[4:0] = 5'h0F; bus.req_data[31:0] = 32'hA1; step();
    bus.req_data[31:0] = 32'hA2; step();
    chk("s_addr0", bus.bram_addr, 0); chk("s_din0", bus.bram_din, 32'hA1); chk("s_we0", bus.bram_we, 5'h0F);
    bus.req_data[31:0] = 32'hA3; step();
    chk("s_addr1", bus.bram_addr, 1); chk("s_din1", bus.bram_din, 32'hA2);
    bus.req_we = '0; step();
    chk("s_addr2", bus.bram_addr, 2); chk("s_din2", bus.bram_din, 32'hA3);
    step();
    chk("s_idle_we", bus.bram_we, 0);
    // asynchronous reset mid-operation
    #2 rst = 1'b1;
    #1;
    chk("arst_addr", bus.bram_addr, 0); chk("arst_din", bus.bram_din, 0); chk("arst_locked", bus.req_locked, 0);
    step(); rst = 1'b0; step();
    chk("arst_rel_locked", bus.req_locked, 2'b11);
    // collisions
    bus.req_start = 2'b11; step(); bus.req_start = '0;
    chk("c_locked", bus.req_locked, 2'b00);
    bus.req_we = {5'h0F, 5'h0F}; bus.req_data = {32'hC0, 32'hB0}; step();
    bus.req_we = '0; step();
    chk("c1_addr_a", bus.bram_addr, 0); chk("c1_din_a", bus.bram_din, 32'hB0);
    step();
    chk("c1_addr_b", bus.bram_addr, 8); chk("c1_din_b", bus.bram_din, 32'hC0);
    bus.req_we[4:0] = 5'h0F; bus.req_data[31:0] = 32'hB1; step();
    bus.req_we = '0; step();
    chk("c_b1_addr", bus.bram_addr, 1); chk("c_b1_din", bus.bram_din, 32'hB1);
    bus.req_we = {5'h0F, 5'h0F}; bus.req_data = {32'hC1, 32'hB2}; step();
    bus.req_we = '0; step();
    chk("c2_addr_a", bus.bram_addr, 9); chk("c2_din_a", bus.bram_din, 32'hC1);
    step();
    chk("c2_addr_b", bus.bram_addr, 2); chk("c2_din_b", bus.bram_din, 32'hB2);
    // fill channel 0 to the end of its region
    bus.req_we[4:0] = 5'h0F;
    for (int k = 0; k < 5; k++) begin
      bus.req_data[31:0] = 32'hD3 + k;
      step();
      if (k > 0) begin
        chk("f_addr", bus.bram_addr, 64'(k + 2));
        chk("f_din", bus.bram_din, 64'(32'hD3 + k - 1));
      end
    end
    bus.req_we = '0; step();
    chk("f_last_addr", bus.bram_addr, 7); chk("f_last_din", bus.bram_din, 32'hD7);
    chk("f_locked", bus.req_locked, 2'b01); chk("f_full", bus.region_full, 2'b01);
    bus.req_we[4:0] = 5'h0F; bus.req_data[31:0] = 32'hEE; step();
    bus.req_we = '0; step();
    chk("full_drop_we", bus.bram_we, 0); chk("full_drop_ovf", bus.ovf_cnt, 1);
    bus.rd_done = 2'b01; step(); bus.rd_done = '0;
    chk("rd_full", bus.region_full, 0); chk("rd_locked", bus.req_locked, 2'b01);
    // restart mid-fill
    bus.req_start = 2'b01; step(); bus.req_start = '0;
    bus.req_we[4:0] = 5'h0F;
    for (int k = 0; k < 5; k++) begin
      bus.req_data[31:0] = 32'hE0 + k;
      step();
    end
    bus.req_we = '0; step();
    chk("r_addr4", bus.bram_addr, 4); chk("r_din4", bus.bram_din, 32'hE4); chk("r_locked", bus.req_locked, 0);
    bus.req_start = 2'b01; step(); bus.req_start = '0;
    bus.req_we[4:0] = 5'h0F; bus.req_data[31:0] = 32'hF0; step();
    bus.req_we = '0; step();
    chk("r_addr0", bus.bram_addr, 0); chk("r_din0", bus.bram_din, 32'hF0); chk("r_ovf", bus.ovf_cnt, 1);
    // overrun while channel 0 is starved by channel 1
    bus.req_we = {5'h0F, 5'h0F}; bus.req_data = {32'h222, 32'h111}; step();
    bus.req_we = {5'h00, 5'h0F}; bus.req_data[31:0] = 32'h333; step();
    bus.req_we = '0;
    chk("o_addr_ch1", bus.bram_addr, 10); chk("o_din_ch1", bus.bram_din, 32'h222); chk("o_ovf", bus.ovf_cnt, 2);
    step();
    chk("o_addr_ch0", bus.bram_addr, 1); chk("o_din_ch0", bus.bram_din, 32'h111); chk("o_we_ch0", bus.bram_we, 5'h0F);
    step();
    chk("o_no_extra", bus.bram_we, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bram_wr_arbiter.md
Name: bram_wr_arbiter

Overview:
Shares one BRAM write port between N_REQ packer channels (VSK/NSK soft-data packers). Each channel owns a fixed BRAM region and writes into it through a one-word holding register.
- Round-robin arbitration grants one write per cycle.
- Per-region fill state machine with lock/unlock handshake towards the packer (locked_we) and the AXI reader (region_full / rd_done).
- Sits between the packer instances and the BRAM port A, in the clk_120 domain.

Parameters:
N_REQ, 2, number of requesting packer channels (2..8)
DATA_W, 32, packed word width
WE_W, 5, write-strobe width passed through to BRAM
REGION_DEPTH, 1024, words per channel region (power of two)
PTR_W, 10, log2(REGION_DEPTH)
ADDR_W, 11, BRAM address width, >= PTR_W + log2(N_REQ)
OVF_W, 16, drop-counter width

Ports:
clk_120  in  1  system clock
rst  in  1  asynchronous, active-high reset
req_we  in  N_REQ*WE_W  per-channel write strobe; nonzero = valid word this cycle
req_data  in  N_REQ*DATA_W  per-channel packed word
req_start  in  N_REQ  start of packet; restarts the region write pointer
rd_done  in  N_REQ  AXI reader finished draining the region (single-cycle pulse)
req_locked  out  N_REQ  region not accepting; drives packer locked_we
region_full  out  N_REQ  region complete, ready for readout
bram_addr  out  ADDR_W  BRAM write address
bram_din  out  DATA_W  BRAM write data
bram_we  out  WE_W  BRAM write strobe; 0 = no write
ovf_cnt  out  OVF_W  saturating count of dropped words, all channels

Behaviour:
- Reset (async, active-high): every output is 0. All holding registers are empty. Round-robin pointer = 0. All regions are in IDLE.
- Region FSM per channel, with states IDLE, FILL, FULL:
  - IDLE -> FILL on req_start; wr_ptr <= 0.
  - FILL: req_start sets wr_ptr <= 0 and discards the pending holding word, uncounted.
  - FILL -> FULL when the word at wr_ptr = REGION_DEPTH-1 is written.
  - FULL -> IDLE on rd_done. If rd_done and req_start coincide, go FULL -> FILL with wr_ptr = 0.
  - req_start alone in FULL is ignored.
- req_locked[i] = 1 in IDLE and FULL. region_full[i] = 1 only in FULL. Both are registered.
- Capture: in FILL, a nonzero req_we[i] loads hold[i] (data + strobe).
  - If hold[i] is already occupied and not granted this cycle, the new word is dropped and ovf_cnt increments.
  - A nonzero req_we in FULL is dropped and counted.
  - A nonzero req_we in IDLE is dropped and not counted.
- req_start and req_we in the same cycle: the start applies first, so the word is captured as the first word (address offset 0).
- Arbitration: combinational over occupied holds. Round-robin starts at pointer p; after a grant to channel g, p <= g+1 mod N_REQ. Exactly one grant per cycle.
- Write: registered. The edge after a grant drives:
  - bram_addr = g*REGION_DEPTH + wr_ptr[g]
  - bram_din = hold[g].data
  - bram_we = hold[g].we
  - wr_ptr[g] increments and hold[g] empties.
  - With no grant, bram_we = 0; addr/din hold their last value.
- Latency: an uncontended word appears on bram_* 2 cycles after req_we (capture edge, then write edge). Worst-case wait is N_REQ-1 extra cycles.
- Same-cycle grant and capture on one channel: the hold refills with no drop.
- ovf_cnt saturates at all-ones. Only rst clears it.

Optional Feature:
ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest channel index wins; the round-robin pointer is removed.
- Undefined (default): round-robin as specified above.

Decomposition:
- Package bram_arb_pkg holds:
  - region_state_t enum {IDLE, FILL, FULL}
  - hold_t struct {valid, we, data}
  - localparam helpers for the region base address
- Sub-module rr_arbiter (N inputs, one-hot grant, pointer update). It also contains the fixed-priority variant under the macro.

Test Plan:
All scenarios use N_REQ=2, REGION_DEPTH=8, WE_W=5.
1. Reset: assert rst mid-operation -> all outputs 0 immediately (async); after release, req_locked = 2'b11 (IDLE).
2. Single channel: req_start[0], then words 0xA1, 0xA2, 0xA3 with we=5'h0F -> bram_addr 0,1,2, din A1..A3, each 2 cycles after its req_we.
3. Collision: both channels valid in the same cycle with p=0 -> ch0 written at addr 0, then ch1 at addr 8 next cycle; second collision -> ch1 first.
4. Fill/lock: 8 words on ch0 -> after the 8th write, req_locked[0]=1 and region_full[0]=1; 9th word -> no write, ovf_cnt=1; rd_done[0] -> IDLE, region_full[0]=0.
5. Restart: req_start[0] after 5 words in FILL -> next word at addr 0, ovf_cnt unchanged.
6. Overrun: ch0 hold occupied and starved, new req_we -> ovf_cnt +1, original word written intact.
